int_stim_gen: RTL and testbench

INT_STIM_GEN -- requirements
Module: int_stim_gen

---
 rtl/int_stim_pkg.sv | 15 +
 rtl/int_stim_chan.sv | 106 ++++++++++
 rtl/int_stim_gen.sv | 89 ++++++++
 tb/tb_int_stim_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_stim_pkg.sv
// Shared definitions for the interrupt stimulus generator: the per-channel
// state enum, the default acknowledge address and the counter width.
package int_stim_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } chan_state_e;

    localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h7F20;
    localparam int unsigned CNT_W            = 8;

endpackage

// File: rtl/int_stim_chan.sv
// One interrupt channel: trigger-PC register, state machine, pulse-length
// counter and fire counter. fire_done pulses in the cycle a firing completes.
module int_stim_chan
    import int_stim_pkg::*;
#(
    parameter int unsigned PULSE_W   = 0,
    parameter int unsigned MAX_FIRES = 1,
    parameter logic [31:0] INIT_PC   = 32'h3010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_aligned,
    input  logic        ack,
    input  logic        cfg_wr,
    input  logic [31:0] cfg_pc,
    output logic        irq,
    output logic        done,
    output logic        fire_done
);

    localparam int unsigned     PULSE_LAST = (PULSE_W > 0) ? PULSE_W - 1 : 0;
    localparam int unsigned     PCNT_W     = (PULSE_LAST > 0) ? $clog2(PULSE_LAST + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_F     = CNT_W'(MAX_FIRES);

    chan_state_e       state_q, state_d;
    logic [31:0]       trig_pc_q, trig_pc_d;
    logic [CNT_W-1:0]  fires_q, fires_d;
    logic [PCNT_W-1:0] pulse_q, pulse_d;
    logic              irq_q, irq_d;
    logic              done_q, done_d;
    logic              pend_end;

    // Next-state logic; a cfg write overrides any trigger or ack this cycle
    always_comb begin
        state_d   = state_q;
        trig_pc_d = trig_pc_q;
        fires_d   = fires_q;
        pulse_d   = pulse_q;
        pend_end  = 1'b0;
        fire_done = 1'b0;
        if (cfg_wr) begin
            trig_pc_d = cfg_pc;
            state_d   = ST_ARMED;
            fires_d   = '0;
            pulse_d   = '0;
        end else begin
            unique case (state_q)
                ST_ARMED: begin
                    if (pc_aligned == trig_pc_q) begin
                        state_d = ST_PENDING;
                        pulse_d = '0;
                    end
                end
                ST_PENDING: begin
                    if (PULSE_W == 0) begin
                        pend_end = ack;
                    end else begin
                        pend_end = ack || (pulse_q == PCNT_W'(PULSE_LAST));
                    end
                    pulse_d = pulse_q + 1'b1;
                    if (pend_end) begin
                        fire_done = 1'b1;
                        fires_d   = fires_q + 1'b1;
                        state_d   = (fires_d >= MAX_F) ? ST_DONE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (pc_aligned != trig_pc_q) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
        irq_d  = (state_d == ST_PENDING);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ARMED;
            trig_pc_q <= INIT_PC;
            fires_q   <= '0;
            pulse_q   <= '0;
            irq_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_pc_q <= trig_pc_d;
            fires_q   <= fires_d;
            pulse_q   <= pulse_d;
            irq_q     <= irq_d;
            done_q    <= done_d;
        end
    end

    assign irq  = irq_q;
    assign done = done_q;

endmodule

// File: rtl/int_stim_gen.sv
// Interrupt stimulus generator: NCH channels raise irq when the CPU PC hits
// their trigger address and drop it on a store to ACK_ADDR (or after PULSE_W
// cycles). Optional macro INT_STIM_ACK_MASK_EN makes the ack per-channel,
// selected by m_data_wdata bits.
module int_stim_gen
    import int_stim_pkg::*;
#(
    parameter int unsigned       NCH       = 3,
    parameter logic [31:0]       ACK_ADDR  = ACK_ADDR_DEFAULT,
    parameter int unsigned       PULSE_W   = 0,
    parameter int unsigned       MAX_FIRES = 1,
    parameter logic [NCH*32-1:0] INIT_PC   = {NCH{32'h3010}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_data_addr,
    input  logic [3:0]       m_data_byteen,
    input  logic [31:0]      m_data_wdata,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [31:0]      cfg_pc,
    output logic [NCH-1:0]   irq,
    output logic             interrupt,
    output logic [CNT_W-1:0] fire_total,
    output logic             all_done
);

    logic [31:0]      pc_aligned;
    logic             ack_hit;
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   fire_done;
    logic [3:0]       fire_sum;
    logic [CNT_W:0]   total_ext;
    logic [CNT_W-1:0] fire_total_q, fire_total_d;
    logic             unused_wdata;

    assign pc_aligned   = macroscopic_pc & ~32'd3;
    assign ack_hit      = (|m_data_byteen) && ((m_data_addr & ~32'd3) == ACK_ADDR);
    assign unused_wdata = ^m_data_wdata;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic ack_i;
`ifdef INT_STIM_ACK_MASK_EN
        assign ack_i = ack_hit && m_data_wdata[i];
`else
        assign ack_i = ack_hit;
`endif
        int_stim_chan #(
            .PULSE_W   (PULSE_W),
            .MAX_FIRES (MAX_FIRES),
            .INIT_PC   (INIT_PC[i*32 +: 32])
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .pc_aligned (pc_aligned),
            .ack        (ack_i),
            .cfg_wr     (cfg_we && (cfg_ch == 3'(i))),
            .cfg_pc     (cfg_pc),
            .irq        (irq[i]),
            .done       (done[i]),
            .fire_done  (fire_done[i])
        );
    end

    // Saturating sum of firings completed across all channels this cycle
    always_comb begin
        fire_sum = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            fire_sum = fire_sum + {3'b000, fire_done[k]};
        end
        total_ext    = {1'b0, fire_total_q} + (CNT_W + 1)'(fire_sum);
        fire_total_d = total_ext[CNT_W] ? '1 : total_ext[CNT_W-1:0];
    end

    // Fire total register, cleared by reset so a pending firing is never counted
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_total_q <= '0;
        end else begin
            fire_total_q <= fire_total_d;
        end
    end

    assign fire_total = fire_total_q;
    assign interrupt  = |irq;
    assign all_done   = &done;

endmodule

// File: tb/tb_int_stim_gen.sv
// Self-checking bench for int_stim_gen: three instances (defaults,
// MAX_FIRES=2, PULSE_W=4) share one input stream and are compared every
// cycle against a behavioural model, plus a vector table and directed
// sequences for retrigger, pulse length, cfg and reset corner cases.
module tb_int_stim_gen;

    localparam int NCH = 3;
    localparam int ND  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc, addr, wdata, cfg_pc;
    logic [3:0]        be;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [NCH-1:0]    irq_a, irq_b, irq_c;
    logic              int_a, int_b, int_c;
    logic [7:0]        ft_a, ft_b, ft_c;
    logic              done_a, done_b, done_c;

    always #5 clk = ~clk;

    int_stim_gen dut_a (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr),
        .m_data_byteen(be), .m_data_wdata(wdata), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_pc(cfg_pc), .irq(irq_a), .interrupt(int_a), .fire_total(ft_a), .all_done(done_a)
    );
    int_stim_gen #(.MAX_FIRES(2)) dut_b (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr),
        .m_data_byteen(be), .m_data_wdata(wdata), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_pc(cfg_pc), .irq(irq_b), .interrupt(int_b), .fire_total(ft_b), .all_done(done_b)
    );
    int_stim_gen #(.PULSE_W(4)) dut_c (
        .clk(clk), .reset(reset), .macroscopic_pc(pc), .m_data_addr(addr),
        .m_data_byteen(be), .m_data_wdata(wdata), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_pc(cfg_pc), .irq(irq_c), .interrupt(int_c), .fire_total(ft_c), .all_done(done_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    endtask

    // Behavioural model: per channel, is it raising irq, waiting for the PC
    // to leave, retired, how long it has been raising, how often it fired.
    int unsigned m_pw [ND] = '{0, 0, 4};
    int unsigned m_mf [ND] = '{1, 2, 1};
    logic [31:0] m_trig  [ND][NCH];
    bit          m_pend  [ND][NCH];
    bit          m_hold  [ND][NCH];
    bit          m_done  [ND][NCH];
    int unsigned m_age   [ND][NCH];
    int unsigned m_fires [ND][NCH];
    int unsigned m_total [ND];

    task automatic model_step();
        bit          ack, ack_c, ends;
        logic [31:0] pcw;
        ack = (be != 4'h0) && ((addr >> 2) == (32'h7F20 >> 2));
        pcw = (pc >> 2) << 2;
        for (int d = 0; d < ND; d++) begin
            if (reset) m_total[d] = 0;
            for (int c = 0; c < NCH; c++) begin
                ack_c = ack;
`ifdef INT_STIM_ACK_MASK_EN
                ack_c = ack && wdata[c];
`endif
                if (reset) begin
                    m_trig[d][c] = 32'h3010;
                    m_pend[d][c] = 0; m_hold[d][c] = 0; m_done[d][c] = 0;
                    m_age[d][c] = 0;  m_fires[d][c] = 0;
                end else if (cfg_we && int'(cfg_ch) == c) begin
                    m_trig[d][c] = cfg_pc;
                    m_pend[d][c] = 0; m_hold[d][c] = 0; m_done[d][c] = 0;
                    m_fires[d][c] = 0;
                end else if (m_done[d][c]) begin
                    // retired
                end else if (m_hold[d][c]) begin
                    if (pcw != m_trig[d][c]) m_hold[d][c] = 0;
                end else if (m_pend[d][c]) begin
                    m_age[d][c]++;
                    ends = ack_c || (m_pw[d] > 0 && m_age[d][c] == m_pw[d]);
                    if (ends) begin
                        m_pend[d][c] = 0;
                        m_fires[d][c]++;
                        if (m_total[d] < 255) m_total[d]++;
                        if (m_fires[d][c] == m_mf[d]) m_done[d][c] = 1;
                        else m_hold[d][c] = 1;
                    end
                end else if (pcw == m_trig[d][c]) begin
                    m_pend[d][c] = 1;
                    m_age[d][c]  = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] act_irq(input int d);
        return (d == 0) ? 32'(irq_a) : (d == 1) ? 32'(irq_b) : 32'(irq_c);
    endfunction
    function automatic logic [31:0] act_int(input int d);
        return (d == 0) ? 32'(int_a) : (d == 1) ? 32'(int_b) : 32'(int_c);
    endfunction
    function automatic logic [31:0] act_ft(input int d);
        return (d == 0) ? 32'(ft_a) : (d == 1) ? 32'(ft_b) : 32'(ft_c);
    endfunction
    function automatic logic [31:0] act_done(input int d);
        return (d == 0) ? 32'(done_a) : (d == 1) ? 32'(done_b) : 32'(done_c);
    endfunction

    task automatic model_check();
        logic [31:0] e_irq;
        bit          e_all;
        for (int d = 0; d < ND; d++) begin
            e_irq = '0;
            e_all = 1;
            for (int c = 0; c < NCH; c++) begin
                e_irq[c] = m_pend[d][c];
                e_all    = e_all && m_done[d][c];
            end
            chk("model_irq", d, act_irq(d), e_irq);
            chk("model_interrupt", d, act_int(d), 32'(e_irq != 0));
            chk("model_fire_total", d, act_ft(d), m_total[d]);
            chk("model_all_done", d, act_done(d), 32'(e_all));
        end
    endtask

    // One clock: DUT and model both consume the inputs held across the edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] a, input logic [3:0] b);
        reset = r; pc = p; addr = a; be = b; wdata = '1;
        cfg_we = 1'b0; cfg_ch = 3'd0; cfg_pc = 32'h0;
        cycle();
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        cwe;
        logic [2:0]  cch;
        logic [31:0] cpc;
        logic [2:0]  e_irq;
        logic [7:0]  e_ft;
        logic        e_done;
    } vec_t;

    vec_t tbl [16];

    logic [31:0] pcs   [6] = '{32'h3010, 32'h3011, 32'h3020, 32'h3030, 32'h0, 32'h3014};
    logic [31:0] addrs [4] = '{32'h7F20, 32'h7F23, 32'h7F24, 32'h100};
    logic [31:0] cpcs  [3] = '{32'h3010, 32'h3020, 32'h3030};

    initial begin
        int hi_cnt;
        reset = 1'b1; pc = '0; addr = '0; be = '0; wdata = '1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_pc = '0;

        // rst, pc, addr, be, cfg_we, cfg_ch, cfg_pc, exp irq/fire_total/all_done (default instance)
        tbl[0]  = '{1'b1, 32'h0,    32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b000, 8'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'h3010, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b111, 8'd0, 1'b0};
        tbl[2]  = '{1'b0, 32'h3014, 32'h7F20, 4'hF, 1'b0, 3'd0, 32'h0,    3'b000, 8'd3, 1'b1};
        tbl[3]  = '{1'b0, 32'h0,    32'h7F20, 4'hF, 1'b0, 3'd0, 32'h0,    3'b000, 8'd3, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,    32'h0,    4'h0, 1'b1, 3'd1, 32'h3020, 3'b000, 8'd3, 1'b0};
        tbl[5]  = '{1'b0, 32'h3020, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b010, 8'd3, 1'b0};
        tbl[6]  = '{1'b0, 32'h3010, 32'h0,    4'h0, 1'b1, 3'd7, 32'h3010, 3'b010, 8'd3, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,    32'h7F24, 4'h1, 1'b0, 3'd0, 32'h0,    3'b010, 8'd3, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,    32'h7F22, 4'h1, 1'b0, 3'd0, 32'h0,    3'b000, 8'd4, 1'b1};
        tbl[9]  = '{1'b0, 32'h3020, 32'h0,    4'h0, 1'b1, 3'd1, 32'h3020, 3'b000, 8'd4, 1'b0};
        tbl[10] = '{1'b0, 32'h3020, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b010, 8'd4, 1'b0};
        tbl[11] = '{1'b1, 32'h3020, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b000, 8'd0, 1'b0};
        tbl[12] = '{1'b0, 32'h3020, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b000, 8'd0, 1'b0};
        tbl[13] = '{1'b0, 32'h3013, 32'h0,    4'h0, 1'b0, 3'd0, 32'h0,    3'b111, 8'd0, 1'b0};
        tbl[14] = '{1'b0, 32'h0,    32'h7F20, 4'h0, 1'b0, 3'd0, 32'h0,    3'b111, 8'd0, 1'b0};
        tbl[15] = '{1'b0, 32'h0,    32'h7F20, 4'h8, 1'b0, 3'd0, 32'h0,    3'b000, 8'd3, 1'b1};

        #2;
        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; pc = tbl[i].pc; addr = tbl[i].addr; be = tbl[i].be;
            wdata = '1; cfg_we = tbl[i].cwe; cfg_ch = tbl[i].cch; cfg_pc = tbl[i].cpc;
            cycle();
            chk($sformatf("tbl%0d_irq", i), 0, 32'(irq_a), 32'(tbl[i].e_irq));
            chk($sformatf("tbl%0d_fire_total", i), 0, 32'(ft_a), 32'(tbl[i].e_ft));
            chk($sformatf("tbl%0d_all_done", i), 0, 32'(done_a), 32'(tbl[i].e_done));
        end

        // Two firings per channel: no refire while the PC sits on the trigger
        drive(1'b1, 32'h0, 32'h0, 4'h0);
        drive(1'b0, 32'h3010, 32'h0, 4'h0);
        chk("mf2_first_irq", 1, 32'(irq_b), 32'h7);
        drive(1'b0, 32'h3010, 32'h7F20, 4'h3);
        chk("mf2_ack_irq", 1, 32'(irq_b), 32'h0);
        chk("mf2_ack_total", 1, 32'(ft_b), 32'd3);
        chk("mf2_ack_done", 1, 32'(done_b), 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h3010, 32'h0, 4'h0);
            chk("mf2_holdoff_irq", 1, 32'(irq_b), 32'h0);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("mf2_leave_irq", 1, 32'(irq_b), 32'h0);
        drive(1'b0, 32'h3010, 32'h0, 4'h0);
        chk("mf2_second_irq", 1, 32'(irq_b), 32'h7);
        drive(1'b0, 32'h3014, 32'h7F20, 4'h1);
        chk("mf2_final_irq", 1, 32'(irq_b), 32'h0);
        chk("mf2_final_total", 1, 32'(ft_b), 32'd6);
        chk("mf2_final_done", 1, 32'(done_b), 32'h1);

        // Pulse mode: irq high for exactly four cycles without any ack
        drive(1'b1, 32'h0, 32'h0, 4'h0);
        drive(1'b0, 32'h3010, 32'h0, 4'h0);
        hi_cnt = (irq_c == 3'b111) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0);
            if (irq_c == 3'b111) hi_cnt++;
        end
        chk("pulse_high_cycles", 2, 32'(hi_cnt), 32'd4);
        chk("pulse_irq_end", 2, 32'(irq_c), 32'h0);
        chk("pulse_total", 2, 32'(ft_c), 32'd3);
        chk("pulse_done", 2, 32'(done_c), 32'h1);

        // Randomized traffic, checked against the model every cycle
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 63) == 0);
            pc     = pcs[$urandom_range(0, 5)];
            addr   = addrs[$urandom_range(0, 3)];
            be     = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            wdata  = $urandom;
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_pc = cpcs[$urandom_range(0, 2)];
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
